// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I(+M) control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath muxes, write enables and memory/MDU handshakes.
module mc_control_unit #(
    parameter bit ENABLE_M     = 1'b0,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    input  logic        mdu_done,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_src,
    output logic        alu_b_src,
    output logic [3:0]  alu_op,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        illegal,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExec    = 3'd2,
        StMem     = 3'd3,
        StMduWait = 3'd4,
        StWb      = 3'd5,
        StHalt    = 3'd6
    } state_e;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpFence  = 7'b0001111;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSll  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluSlt  = 4'd8;
    localparam logic [3:0] AluSltu = 4'd9;

    state_e      state_q, state_d;
    logic [31:0] ir_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_ir;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_fence, is_mdu, legal;
    logic [3:0] alu_arith;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                ir_q <= instr;
            end
        end
    end

    // Instruction classification and legality from the IR.
    always_comb begin
        is_r      = 1'b0;
        is_i      = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_fence  = 1'b0;
        is_mdu    = 1'b0;
        legal     = 1'b0;
        unique case (opcode)
            OpReg: begin
                if (funct7 == 7'b0000000) begin
                    is_r  = 1'b1;
                    legal = 1'b1;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    is_r  = 1'b1;
                    legal = 1'b1;
                end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                    is_mdu = 1'b1;
                    legal  = 1'b1;
                end
            end
            OpImm: begin
                is_i = 1'b1;
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    legal = 1'b1;
                end
            end
            OpLoad: begin
                is_load = 1'b1;
                legal   = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
            end
            OpStore: begin
                is_store = 1'b1;
                legal    = (funct3 < 3'b011);
            end
            OpBranch: begin
                is_branch = 1'b1;
                legal     = (funct3[2:1] != 2'b01);
            end
            OpJal: begin
                is_jal = 1'b1;
                legal  = 1'b1;
            end
            OpJalr: begin
                is_jalr = 1'b1;
                legal   = 1'b1;
            end
            OpLui: begin
                is_lui = 1'b1;
                legal  = 1'b1;
            end
            OpAuipc: begin
                is_auipc = 1'b1;
                legal    = 1'b1;
            end
            OpFence: begin
                is_fence = 1'b1;
                legal    = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate-form 000 is always addi; only register form uses funct7[5] for sub.
    always_comb begin
        alu_arith = AluAdd;
        unique case (funct3)
            3'b000:  alu_arith = (is_r && funct7[5]) ? AluSub : AluAdd;
            3'b001:  alu_arith = AluSll;
            3'b010:  alu_arith = AluSlt;
            3'b011:  alu_arith = AluSltu;
            3'b100:  alu_arith = AluXor;
            3'b101:  alu_arith = funct7[5] ? AluSra : AluSrl;
            3'b110:  alu_arith = AluOr;
            default: alu_arith = AluAnd;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        alu_a_src  = 2'b00;
        alu_b_src  = 1'b0;
        alu_op     = AluAdd;
        mdu_start  = 1'b0;
        mdu_op     = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    if (!legal) begin
                        illegal = 1'b1;
                        if (ILLEGAL_HALT) begin
                            state_d = StHalt;
                        end else begin
                            pc_we   = 1'b1;
                            state_d = StFetch;
                        end
                    end else if (is_fence) begin
                        pc_we   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    state_d = StWb;
                    if (is_r) begin
                        alu_op = alu_arith;
                    end else if (is_i) begin
                        alu_b_src = 1'b1;
                        alu_op    = alu_arith;
                    end else if (is_load || is_store) begin
                        alu_b_src = 1'b1;
                        state_d   = StMem;
                    end else if (is_lui) begin
                        alu_a_src = 2'b10;
                        alu_b_src = 1'b1;
                    end else if (is_auipc) begin
                        alu_a_src = 2'b01;
                        alu_b_src = 1'b1;
                    end else if (is_branch) begin
                        alu_op  = AluSub;
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? 2'b01 : 2'b00;
                        state_d = StFetch;
                    end else if (is_jal) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b01;
                    end else if (is_jalr) begin
                        alu_b_src = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = 2'b10;
                    end else if (is_mdu) begin
                        mdu_start = 1'b1;
                        mdu_op    = funct3;
                        state_d   = StMduWait;
                    end
                end
                StMem: begin
                    mem_read  = is_load;
                    mem_write = is_store;
                    if (dmem_ready) begin
                        if (is_load) begin
                            state_d = StWb;
                        end else begin
                            pc_we   = 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
                StMduWait: begin
                    if (mdu_done) begin
                        state_d = StWb;
                    end
                end
                StWb: begin
                    reg_write = 1'b1;
                    if (is_load) begin
                        mem_to_reg = 2'b01;
                    end else if (is_jal || is_jalr) begin
                        mem_to_reg = 2'b10;
                    end else if (is_mdu) begin
                        mem_to_reg = 2'b11;
                    end
                    // Jumps already redirected the PC in EXEC.
                    pc_we   = !(is_jal || is_jalr);
                    state_d = StFetch;
                end
                StHalt: begin
                    halted = 1'b1;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: table vectors, directed multi-cycle sequences and random
// instructions checked cycle by cycle against a trace-level reference model.
module tb_mc_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0][31:0] instr;
    logic [1:0]       imem_ready, dmem_ready, br_taken, mdu_done;
    logic [1:0]       imem_req, ir_we, pc_we, alu_b_src, mdu_start;
    logic [1:0]       mem_read, mem_write, reg_write, illegal, halted;
    logic [1:0][1:0]  pc_src, alu_a_src, mem_to_reg;
    logic [1:0][3:0]  alu_op;
    logic [1:0][2:0]  mdu_op, state;

    // Instance 0: M enabled, skip illegal. Instance 1: M disabled, halt on illegal.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_control_unit #(
            .ENABLE_M    ((g == 0) ? 1'b1 : 1'b0),
            .ILLEGAL_HALT((g == 1) ? 1'b1 : 1'b0)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .instr     (instr[g]),
            .imem_ready(imem_ready[g]),
            .dmem_ready(dmem_ready[g]),
            .br_taken  (br_taken[g]),
            .mdu_done  (mdu_done[g]),
            .imem_req  (imem_req[g]),
            .ir_we     (ir_we[g]),
            .pc_we     (pc_we[g]),
            .pc_src    (pc_src[g]),
            .alu_a_src (alu_a_src[g]),
            .alu_b_src (alu_b_src[g]),
            .alu_op    (alu_op[g]),
            .mdu_start (mdu_start[g]),
            .mdu_op    (mdu_op[g]),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .mem_to_reg(mem_to_reg[g]),
            .reg_write (reg_write[g]),
            .illegal   (illegal[g]),
            .halted    (halted[g]),
            .state     (state[g])
        );
    end

    typedef struct packed {
        logic       imem_req, ir_we, pc_we;
        logic [1:0] pc_src, alu_a_src;
        logic       alu_b_src;
        logic [3:0] alu_op;
        logic       mdu_start;
        logic [2:0] mdu_op;
        logic       mem_read, mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write, illegal, halted;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        logic        r, iready, dready, br, mdone;
        logic [31:0] w;
        outs_t       exp;
    } cyc_t;

    typedef struct {
        logic [31:0] w;
        int          cycles;
        logic [3:0]  alu;
        bit          ill;
    } vec_t;

    localparam int CIll = 0, CFence = 1, CR = 2, CI = 3, CLoad = 4, CStore = 5, CBr = 6;
    localparam int CJal = 7, CJalr = 8, CLui = 9, CAuipc = 10, CMdu = 11;

    int checks = 0;
    int failures = 0;
    cyc_t tr[$];
    vec_t tbl[$];
    logic [31:0] cur_w;
    int mon_cnt, n_rd, n_start, n_rw, n_ill, n_halted;
    bit mon_left, mon_done;
    logic [3:0] mon_alu;
    logic [1:0] mon_exec_pcsrc, wb_m2r;
    logic [2:0] start_op;

    function automatic logic rb();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outs_t get_obs(input int k);
        outs_t o;
        o.imem_req   = imem_req[k];
        o.ir_we      = ir_we[k];
        o.pc_we      = pc_we[k];
        o.pc_src     = pc_src[k];
        o.alu_a_src  = alu_a_src[k];
        o.alu_b_src  = alu_b_src[k];
        o.alu_op     = alu_op[k];
        o.mdu_start  = mdu_start[k];
        o.mdu_op     = mdu_op[k];
        o.mem_read   = mem_read[k];
        o.mem_write  = mem_write[k];
        o.mem_to_reg = mem_to_reg[k];
        o.reg_write  = reg_write[k];
        o.illegal    = illegal[k];
        o.halted     = halted[k];
        o.state      = state[k];
        return o;
    endfunction

    // Instruction class from the RV32I/M encoding rules.
    function automatic int classify(input logic [31:0] w, input bit m);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = w[31:25];
        f3 = w[14:12];
        case (w[6:0])
            7'b0110011: begin
                if (f7 == 7'h00) return CR;
                if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return CR;
                if (f7 == 7'h01 && m) return CMdu;
                return CIll;
            end
            7'b0010011: begin
                if (f3 == 3'd1) return (f7 == 7'h00) ? CI : CIll;
                if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? CI : CIll;
                return CI;
            end
            7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? CIll : CLoad;
            7'b0100011: return (f3 >= 3'd3) ? CIll : CStore;
            7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? CIll : CBr;
            7'b1101111: return CJal;
            7'b1100111: return CJalr;
            7'b0110111: return CLui;
            7'b0010111: return CAuipc;
            7'b0001111: return CFence;
            default:    return CIll;
        endcase
    endfunction

    function automatic logic [3:0] mnemonic_alu(input logic [31:0] w, input bit reg_form);
        case (w[14:12])
            3'd0:    return (reg_form && w[30]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd8;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return w[30] ? 4'd7 : 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr, input logic b,
                        input logic md, input logic [31:0] w, input outs_t e);
        cyc_t c;
        c.r = r; c.iready = ir; c.dready = dr; c.br = b; c.mdone = md; c.w = w; c.exp = e;
        tr.push_back(c);
    endtask

    // Expected per-cycle trace of one instruction; unsampled inputs get random noise.
    task automatic build(input int k, input logic [31:0] w, input int iw, input int dw,
                         input int mw, input int br, input int halt_cycles);
        int c;
        bit h;
        logic b;
        outs_t e;
        h = (k == 1);
        c = classify(w, k == 0);
        for (int i = 0; i <= iw; i++) begin
            e = '0; e.imem_req = 1'b1; e.ir_we = (i == iw);
            push(1'b0, i == iw, rb(), rb(), rb(), (i == iw) ? w : $urandom(), e);
        end
        e = '0; e.state = 3'd1;
        if (c == CIll) begin
            e.illegal = 1'b1;
            e.pc_we = !h;
            push(1'b0, rb(), rb(), rb(), rb(), $urandom(), e);
            if (h) begin
                for (int i = 0; i < halt_cycles; i++) begin
                    e = '0; e.halted = 1'b1; e.state = 3'd6;
                    push(1'b0, rb(), rb(), rb(), rb(), $urandom(), e);
                end
                push(1'b1, rb(), rb(), rb(), rb(), $urandom(), '0);
            end
            return;
        end
        if (c == CFence) begin
            e.pc_we = 1'b1;
            push(1'b0, rb(), rb(), rb(), rb(), $urandom(), e);
            return;
        end
        push(1'b0, rb(), rb(), rb(), rb(), $urandom(), e);
        b = (br < 0) ? rb() : br[0];
        e = '0; e.state = 3'd2;
        case (c)
            CR:             e.alu_op = mnemonic_alu(w, 1'b1);
            CI:             begin e.alu_op = mnemonic_alu(w, 1'b0); e.alu_b_src = 1'b1; end
            CLoad, CStore:  e.alu_b_src = 1'b1;
            CLui:           begin e.alu_a_src = 2'd2; e.alu_b_src = 1'b1; end
            CAuipc:         begin e.alu_a_src = 2'd1; e.alu_b_src = 1'b1; end
            CBr:            begin e.alu_op = 4'd1; e.pc_we = 1'b1; e.pc_src = b ? 2'd1 : 2'd0; end
            CJal:           begin e.pc_we = 1'b1; e.pc_src = 2'd1; end
            CJalr:          begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.alu_b_src = 1'b1; end
            CMdu:           begin e.mdu_start = 1'b1; e.mdu_op = w[14:12]; end
            default: ;
        endcase
        push(1'b0, rb(), rb(), b, rb(), $urandom(), e);
        if (c == CBr) return;
        if (c == CLoad || c == CStore) begin
            for (int i = 0; i <= dw; i++) begin
                e = '0; e.state = 3'd3;
                e.mem_read = (c == CLoad);
                e.mem_write = (c == CStore);
                e.pc_we = (c == CStore) && (i == dw);
                push(1'b0, rb(), i == dw, rb(), rb(), $urandom(), e);
            end
            if (c == CStore) return;
        end
        if (c == CMdu) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.state = 3'd4;
                push(1'b0, rb(), rb(), rb(), i == mw, $urandom(), e);
            end
        end
        e = '0; e.state = 3'd5; e.reg_write = 1'b1;
        e.mem_to_reg = (c == CLoad) ? 2'd1 : (c == CJal || c == CJalr) ? 2'd2 :
                       (c == CMdu) ? 2'd3 : 2'd0;
        e.pc_we = !(c == CJal || c == CJalr);
        push(1'b0, rb(), rb(), rb(), rb(), $urandom(), e);
    endtask

    // Applies the trace to instance k (the other one idles in FETCH); call at posedge+1.
    task automatic run_trace(input int k);
        outs_t o;
        mon_cnt = 0; mon_left = 0; mon_done = 0; mon_alu = '0; mon_exec_pcsrc = '0;
        n_rd = 0; n_start = 0; n_rw = 0; n_ill = 0; n_halted = 0; wb_m2r = '0; start_op = '0;
        for (int i = 0; i < tr.size(); i++) begin
            rst = tr[i].r;
            instr = '0; imem_ready = '0; dmem_ready = '0; br_taken = '0; mdu_done = '0;
            instr[k] = tr[i].w;
            imem_ready[k] = tr[i].iready;
            dmem_ready[k] = tr[i].dready;
            br_taken[k] = tr[i].br;
            mdu_done[k] = tr[i].mdone;
            @(negedge clk);
            o = get_obs(k);
            check_eq($sformatf("trace inst%0d w=%h cyc%0d", k, cur_w, i),
                     {6'b0, o}, {6'b0, tr[i].exp});
            if (!mon_done) begin
                if (mon_left && o.state == 3'd0) mon_done = 1;
                else begin
                    mon_cnt++;
                    if (o.state != 3'd0) mon_left = 1;
                end
            end
            if (o.state == 3'd2) begin
                mon_alu = o.alu_op;
                mon_exec_pcsrc = o.pc_src;
            end
            n_rd += int'(o.mem_read);
            n_start += int'(o.mdu_start);
            if (o.mdu_start) start_op = o.mdu_op;
            n_rw += int'(o.reg_write);
            if (o.reg_write) wb_m2r = o.mem_to_reg;
            n_ill += int'(o.illegal);
            n_halted += int'(o.halted);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input int k, input logic [31:0] w, input int iw, input int dw,
                            input int mw, input int br, input int hc);
        tr.delete();
        cur_w = w;
        build(k, w, iw, dw, mw, br, hc);
        run_trace(k);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int r;
        w = $urandom();
        r = $urandom_range(0, 12);
        case (r)
            0: w[6:0] = 7'b0110011;  1: w[6:0] = 7'b0010011;  2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;  4: w[6:0] = 7'b1100011;  5: w[6:0] = 7'b1101111;
            6: w[6:0] = 7'b1100111;  7: w[6:0] = 7'b0110111;  8: w[6:0] = 7'b0010111;
            9: w[6:0] = 7'b0001111;  10: w[6:0] = 7'b0110011;
            default: ;
        endcase
        if ((w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) && $urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 2);
            w[31:25] = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'h01;
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t e;
        rst = 1'b1;
        instr = '0; imem_ready = 2'b11; dmem_ready = '0; br_taken = '0; mdu_done = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check_eq($sformatf("reset outputs inst%0d cyc%0d", k, c), {6'b0, get_obs(k)}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ready = '0;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("post-reset fetch inst%0d", k), {6'b0, get_obs(k)}, {6'b0, e});
        @(posedge clk);
        #1;

        tbl.push_back('{32'h002081B3, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h402081B3, 4, 4'd1, 1'b0});
        tbl.push_back('{32'h0020F1B3, 4, 4'd2, 1'b0});
        tbl.push_back('{32'h0020E1B3, 4, 4'd3, 1'b0});
        tbl.push_back('{32'h0020C1B3, 4, 4'd4, 1'b0});
        tbl.push_back('{32'h002091B3, 4, 4'd5, 1'b0});
        tbl.push_back('{32'h0020D1B3, 4, 4'd6, 1'b0});
        tbl.push_back('{32'h4020D1B3, 4, 4'd7, 1'b0});
        tbl.push_back('{32'h0020A1B3, 4, 4'd8, 1'b0});
        tbl.push_back('{32'h0020B1B3, 4, 4'd9, 1'b0});
        tbl.push_back('{32'h4030D193, 4, 4'd7, 1'b0});
        tbl.push_back('{32'h00508193, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h000011B7, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h00001197, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h008000EF, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h000100E7, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h0000A183, 5, 4'd0, 1'b0});
        tbl.push_back('{32'h0020A023, 4, 4'd0, 1'b0});
        tbl.push_back('{32'h00208463, 3, 4'd1, 1'b0});
        tbl.push_back('{32'h0000000F, 2, 4'd0, 1'b0});
        tbl.push_back('{32'h022081B3, 5, 4'd0, 1'b0});
        tbl.push_back('{32'hFFFFFFFF, 2, 4'd0, 1'b1});
        tbl.push_back('{32'h402091B3, 2, 4'd0, 1'b1});
        tbl.push_back('{32'h0000B183, 2, 4'd0, 1'b1});
        tbl.push_back('{32'h0000E183, 2, 4'd0, 1'b1});
        tbl.push_back('{32'h0020B023, 2, 4'd0, 1'b1});
        tbl.push_back('{32'h0020A463, 2, 4'd0, 1'b1});
        tbl.push_back('{32'h40309193, 2, 4'd0, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            do_instr(0, tbl[i].w, 0, 0, 0, -1, 0);
            check_eq($sformatf("tbl%0d cycles", i), mon_cnt, tbl[i].cycles);
            check_eq($sformatf("tbl%0d exec alu_op", i), {28'd0, mon_alu}, {28'd0, tbl[i].alu});
            check_eq($sformatf("tbl%0d illegal", i), n_ill, {31'd0, tbl[i].ill});
        end

        // lw with dmem_ready three cycles late.
        do_instr(0, 32'h0000A183, 0, 3, 0, -1, 0);
        check_eq("lw wait cycles", mon_cnt, 8);
        check_eq("lw wait mem_read cycles", n_rd, 4);
        check_eq("lw wait mem_to_reg", {30'd0, wb_m2r}, 32'd1);

        do_instr(0, 32'h00208463, 0, 0, 0, 1, 0);
        check_eq("beq taken pc_src", {30'd0, mon_exec_pcsrc}, 32'd1);
        check_eq("beq taken cycles", mon_cnt, 3);
        check_eq("beq taken reg_write", n_rw, 0);
        do_instr(0, 32'h00208463, 0, 0, 0, 0, 0);
        check_eq("beq not-taken pc_src", {30'd0, mon_exec_pcsrc}, 32'd0);
        check_eq("beq not-taken reg_write", n_rw, 0);

        do_instr(0, 32'h022081B3, 0, 0, 4, -1, 0);
        check_eq("mul start pulses", n_start, 1);
        check_eq("mul mdu_op", {29'd0, start_op}, 32'd0);
        check_eq("mul mem_to_reg", {30'd0, wb_m2r}, 32'd3);
        check_eq("mul cycles", mon_cnt, 9);

        // M disabled, halting instance: mul is illegal and parks the FSM.
        do_instr(1, 32'h022081B3, 0, 0, 0, -1, 3);
        check_eq("mul no-M illegal pulses", n_ill, 1);
        check_eq("mul no-M reg_write", n_rw, 0);

        tr.delete();
        cur_w = 32'hFFFFFFFF;
        build(1, 32'hFFFFFFFF, 0, 0, 0, -1, 10);
        e = '0; e.imem_req = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, e);
        run_trace(1);
        check_eq("halt illegal pulses", n_ill, 1);
        check_eq("halt halted cycles", n_halted, 10);

        // Reset while a load is stalled in MEM.
        tr.delete();
        cur_w = 32'h0000A183;
        build(0, 32'h0000A183, 0, 6, 0, -1, 0);
        while (tr.size() > 5) void'(tr.pop_back());
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, '0);
        push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, '0);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, e);
        run_trace(0);
        check_eq("rst in MEM reg_write", n_rw, 0);
        check_eq("rst in MEM mem_read cycles", n_rd, 2);

        for (int n = 0; n < 400; n++) begin
            do_instr($urandom_range(0, 1), rand_instr(), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 3), -1, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
